// File: rtl/id_stage_regfile.sv
// id_stage_regfile
// ---------------------------------------------------------------------------
// Decode stage of the pipelined MIPS core. Holds the general-purpose register
// file (register 0 hard-wired to zero), selects the writeback source, bypasses
// a same-cycle writeback onto the read ports, extends the immediate according
// to the opcode and registers the decoded instruction into the ID/EX register.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid              instruction / pc_plus4 carry a real instruction
//   instruction, pc_plus4 instruction word and its PC+4 from IF/ID
//   stall                 hold ID/EX (operand data still refreshed)
//   flush                 load a bubble into ID/EX
//   wb_we, wb_src, wb_dst writeback enable, source select, destination
//   alu_result, mem_data, link_data   writeback candidates
//   ex_*                  registered ID/EX contents (all outputs are flops)
// ---------------------------------------------------------------------------
module id_stage_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [1:0]        wb_src,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] link_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_rs,
    output logic [ADDR_W-1:0] ex_rt,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [5:0]        ex_opcode,
    output logic [5:0]        ex_funct,
    output logic [DATA_W-1:0] ex_pc_plus4
);

    localparam int                NREGS     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    logic [DATA_W-1:0] regs [NREGS];

    // Writeback selection
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_addr;
    logic              wb_src_ok;
    logic              wb_write;

    // Decoded fields of the incoming instruction
    logic [ADDR_W-1:0] dec_rs;
    logic [ADDR_W-1:0] dec_rt;
    logic [ADDR_W-1:0] dec_rd;
    logic [5:0]        dec_opcode;
    logic [5:0]        dec_funct;
    logic [15:0]       imm16;
    logic [DATA_W-1:0] imm_ext;

    // Sign-extension helpers, wider than needed so the low DATA_W bits can be
    // sliced out without a zero-length replication at DATA_W = 32.
    logic [DATA_W+15:0] sext16;
    logic [31:0]        lui_word;
    logic [DATA_W+31:0] sext32;

    // Read ports (address is the held field while stalled)
    logic [ADDR_W-1:0] rd_rs_addr;
    logic [ADDR_W-1:0] rd_rt_addr;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    // Instruction bits not consumed by the decoder (shamt, upper field bits)
    logic unused_instr;

    assign dec_rs       = instruction[21 +: ADDR_W];
    assign dec_rt       = instruction[16 +: ADDR_W];
    assign dec_rd       = instruction[11 +: ADDR_W];
    assign dec_opcode   = instruction[31:26];
    assign dec_funct    = instruction[5:0];
    assign imm16        = instruction[15:0];
    assign unused_instr = ^instruction;

    assign sext16   = {{DATA_W{imm16[15]}}, imm16};
    assign lui_word = {imm16, 16'h0000};
    assign sext32   = {{DATA_W{lui_word[31]}}, lui_word};

    // Writeback source mux; link writebacks are redirected to LINK_ADDR and
    // source 3 is reserved, so it never writes.
    always_comb begin
        wb_data   = '0;
        wb_addr   = wb_dst;
        wb_src_ok = 1'b0;
        case (wb_src)
            2'd0: begin
                wb_data   = alu_result;
                wb_src_ok = 1'b1;
            end
            2'd1: begin
                wb_data   = mem_data;
                wb_src_ok = 1'b1;
            end
            2'd2: begin
                wb_data   = link_data;
                wb_addr   = LINK_ADDR;
                wb_src_ok = 1'b1;
            end
            default: begin
                wb_data   = '0;
                wb_src_ok = 1'b0;
            end
        endcase
        wb_write = wb_we & wb_src_ok & (wb_addr != ZERO_ADDR);
    end

    // Immediate extension chosen by opcode
    always_comb begin
        imm_ext = '0;
        case (dec_opcode)
            OP_ANDI, OP_ORI, OP_XORI: imm_ext = {{(DATA_W-16){1'b0}}, imm16};
            OP_LUI:                   imm_ext = sext32[DATA_W-1:0];
            default:                  imm_ext = sext16[DATA_W-1:0];
        endcase
    end

    // Bypassed register reads; a stall re-reads the held ex_rs/ex_rt so a
    // writeback landing during the stall reaches the held operands.
    always_comb begin
        rd_rs_addr = dec_rs;
        rd_rt_addr = dec_rt;
        if (stall) begin
            rd_rs_addr = ex_rs;
            rd_rt_addr = ex_rt;
        end else begin
            rd_rs_addr = dec_rs;
            rd_rt_addr = dec_rt;
        end

        if (rd_rs_addr == ZERO_ADDR) begin
            rs_val = '0;
        end else if (wb_write && (wb_addr == rd_rs_addr)) begin
            rs_val = wb_data;
        end else begin
            rs_val = regs[rd_rs_addr];
        end

        if (rd_rt_addr == ZERO_ADDR) begin
            rt_val = '0;
        end else if (wb_write && (wb_addr == rd_rt_addr)) begin
            rt_val = wb_data;
        end else begin
            rt_val = regs[rd_rt_addr];
        end
    end

    // Register file storage; reset clears everything and drops any write
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_addr] <= wb_data;
        end else begin
            regs[wb_addr] <= regs[wb_addr];
        end
    end

    // ID/EX pipeline register: reset > flush > stall > load
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            ex_valid    <= 1'b0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_opcode   <= 6'd0;
            ex_funct    <= 6'd0;
            ex_pc_plus4 <= '0;
        end else if (stall) begin
            ex_rs_data  <= rs_val;
            ex_rt_data  <= rt_val;
        end else begin
            ex_valid    <= in_valid;
            ex_rs_data  <= rs_val;
            ex_rt_data  <= rt_val;
            ex_imm      <= imm_ext;
            ex_rs       <= dec_rs;
            ex_rt       <= dec_rt;
            ex_rd       <= dec_rd;
            ex_opcode   <= dec_opcode;
            ex_funct    <= dec_funct;
            ex_pc_plus4 <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_id_stage_regfile.sv
// Self-checking bench for id_stage_regfile: a register-array model checked
// against the default instance every cycle, literal expectations for the
// directed vectors, and a DATA_W=64 / ADDR_W=4 instance checked by literals.
module tb_id_stage_regfile;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // ---------------- default instance ----------------
    logic        reset, in_valid, stall, flush, wb_we;
    logic [31:0] instruction, pc_plus4, alu_result, mem_data, link_data;
    logic [1:0]  wb_src;
    logic [4:0]  wb_dst;
    logic        ex_valid;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_opcode, ex_funct;

    id_stage_regfile dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .instruction(instruction),
        .pc_plus4(pc_plus4), .stall(stall), .flush(flush), .wb_we(wb_we),
        .wb_src(wb_src), .wb_dst(wb_dst), .alu_result(alu_result), .mem_data(mem_data),
        .link_data(link_data), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct(ex_funct), .ex_pc_plus4(ex_pc_plus4)
    );

    // ---------------- 64-bit / 16-register instance ----------------
    logic        w_reset, w_in_valid, w_stall, w_flush, w_wb_we;
    logic [31:0] w_instruction;
    logic [63:0] w_pc_plus4, w_alu_result, w_mem_data, w_link_data;
    logic [1:0]  w_wb_src;
    logic [3:0]  w_wb_dst;
    logic        w_ex_valid;
    logic [63:0] w_ex_rs_data, w_ex_rt_data, w_ex_imm, w_ex_pc_plus4;
    logic [3:0]  w_ex_rs, w_ex_rt, w_ex_rd;
    logic [5:0]  w_ex_opcode, w_ex_funct;

    id_stage_regfile #(.DATA_W(64), .ADDR_W(4), .LINK_REG(15)) dut_w (
        .clock(clock), .reset(w_reset), .in_valid(w_in_valid), .instruction(w_instruction),
        .pc_plus4(w_pc_plus4), .stall(w_stall), .flush(w_flush), .wb_we(w_wb_we),
        .wb_src(w_wb_src), .wb_dst(w_wb_dst), .alu_result(w_alu_result), .mem_data(w_mem_data),
        .link_data(w_link_data), .ex_valid(w_ex_valid), .ex_rs_data(w_ex_rs_data),
        .ex_rt_data(w_ex_rt_data), .ex_imm(w_ex_imm), .ex_rs(w_ex_rs), .ex_rt(w_ex_rt),
        .ex_rd(w_ex_rd), .ex_opcode(w_ex_opcode), .ex_funct(w_ex_funct),
        .ex_pc_plus4(w_ex_pc_plus4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (default instance) ----------------
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_rs_data, m_rt_data, m_imm, m_pc;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [5:0]  m_op, m_fn;

    function automatic int m_waddr();
        return (wb_src == 2'd2) ? 31 : int'(wb_dst);
    endfunction

    function automatic logic [31:0] m_wdata();
        case (wb_src)
            2'd0:    return alu_result;
            2'd1:    return mem_data;
            2'd2:    return link_data;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_wen();
        return wb_we && (wb_src != 2'd3) && (m_waddr() != 0);
    endfunction

    function automatic logic [31:0] m_read(input int a);
        if (a == 0) return 32'h0;
        if (m_wen() && m_waddr() == a) return m_wdata();
        return m_regs[a];
    endfunction

    function automatic logic [31:0] m_ext(input logic [5:0] op, input logic [15:0] i);
        if (op >= 6'h0C && op <= 6'h0E) return {16'h0000, i};
        if (op == 6'h0F) return {i, 16'h0000};
        return i[15] ? {16'hFFFF, i} : {16'h0000, i};
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
            m_valid <= 1'b0; m_rs_data <= 32'h0; m_rt_data <= 32'h0; m_imm <= 32'h0;
            m_pc <= 32'h0; m_rs <= 5'd0; m_rt <= 5'd0; m_rd <= 5'd0; m_op <= 6'd0; m_fn <= 6'd0;
        end else begin
            if (m_wen()) m_regs[m_waddr()] <= m_wdata();
            if (flush) begin
                m_valid <= 1'b0; m_rs_data <= 32'h0; m_rt_data <= 32'h0; m_imm <= 32'h0;
                m_pc <= 32'h0; m_rs <= 5'd0; m_rt <= 5'd0; m_rd <= 5'd0; m_op <= 6'd0; m_fn <= 6'd0;
            end else if (stall) begin
                m_rs_data <= m_read(int'(m_rs));
                m_rt_data <= m_read(int'(m_rt));
            end else begin
                m_valid   <= in_valid;
                m_rs_data <= m_read(int'(instruction[25:21]));
                m_rt_data <= m_read(int'(instruction[20:16]));
                m_imm     <= m_ext(instruction[31:26], instruction[15:0]);
                m_pc      <= pc_plus4;
                m_rs      <= instruction[25:21];
                m_rt      <= instruction[20:16];
                m_rd      <= instruction[15:11];
                m_op      <= instruction[31:26];
                m_fn      <= instruction[5:0];
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clock) begin
        if (started) begin
            chk("model_valid",   64'(ex_valid),    64'(m_valid));
            chk("model_rs_data", 64'(ex_rs_data),  64'(m_rs_data));
            chk("model_rt_data", 64'(ex_rt_data),  64'(m_rt_data));
            chk("model_imm",     64'(ex_imm),      64'(m_imm));
            chk("model_rs",      64'(ex_rs),       64'(m_rs));
            chk("model_rt",      64'(ex_rt),       64'(m_rt));
            chk("model_rd",      64'(ex_rd),       64'(m_rd));
            chk("model_opcode",  64'(ex_opcode),   64'(m_op));
            chk("model_funct",   64'(ex_funct),    64'(m_fn));
            chk("model_pc",      64'(ex_pc_plus4), 64'(m_pc));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Selected source gets val, the others get ~val so a wrong mux shows up
    task automatic wb(input logic we, input logic [1:0] src, input logic [4:0] dst,
                      input logic [31:0] val);
        wb_we = we; wb_src = src; wb_dst = dst;
        alu_result = (src == 2'd0) ? val : ~val;
        mem_data   = (src == 2'd1) ? val : ~val;
        link_data  = (src == 2'd2) ? val : ~val;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; instruction = 32'h0; pc_plus4 = 32'h0;
        stall = 1'b0; flush = 1'b0;
        wb(1'b0, 2'd0, 5'd0, 32'h0);
        w_reset = 1'b1; w_in_valid = 1'b0; w_instruction = 32'h0; w_pc_plus4 = 64'h0;
        w_stall = 1'b0; w_flush = 1'b0; w_wb_we = 1'b0; w_wb_src = 2'd0; w_wb_dst = 4'd0;
        w_alu_result = 64'h0; w_mem_data = 64'h0; w_link_data = 64'h0;
        cyc();
        started = 1'b1;
        chk("reset_valid", 64'(ex_valid), 64'h0);
        chk("reset_rs_data", 64'(ex_rs_data), 64'h0);

        // add $3,$1,$2 after reset
        reset = 1'b0; in_valid = 1'b1; pc_plus4 = 32'h0040_0004;
        instruction = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        cyc();
        chk("add_valid", 64'(ex_valid), 64'h1);
        chk("add_rs_data", 64'(ex_rs_data), 64'h0);
        chk("add_rt_data", 64'(ex_rt_data), 64'h0);
        chk("add_rd", 64'(ex_rd), 64'h3);
        chk("add_funct", 64'(ex_funct), 64'h20);
        chk("add_pc", 64'(ex_pc_plus4), 64'h0040_0004);

        // addi $6,$5,-1 with same-cycle write $5 = 0x1234
        wb(1'b1, 2'd0, 5'd5, 32'h0000_1234);
        instruction = itype(6'h08, 5'd5, 5'd6, 16'hFFFF);
        cyc();
        chk("bypass_rs_data", 64'(ex_rs_data), 64'h1234);
        chk("bypass_imm", 64'(ex_imm), 64'hFFFF_FFFF);
        chk("bypass_rt", 64'(ex_rt), 64'h6);

        // Stored value visible next cycle
        wb(1'b0, 2'd0, 5'd0, 32'h0);
        instruction = itype(6'h08, 5'd5, 5'd0, 16'h0000);
        cyc();
        chk("stored_rs_data", 64'(ex_rs_data), 64'h1234);

        // Link writeback ignores wb_dst
        wb(1'b1, 2'd2, 5'd7, 32'h0040_0008);
        cyc();
        wb(1'b0, 2'd0, 5'd0, 32'h0);
        instruction = itype(6'h08, 5'd31, 5'd7, 16'h0000);
        cyc();
        chk("link_r31", 64'(ex_rs_data), 64'h0040_0008);
        chk("link_r7", 64'(ex_rt_data), 64'h0);

        // Write to $0: no bypass, no storage
        wb(1'b1, 2'd0, 5'd0, 32'h0000_DEAD);
        instruction = itype(6'h08, 5'd0, 5'd0, 16'h0000);
        cyc();
        chk("zero_bypass", 64'(ex_rs_data), 64'h0);
        // Reserved source: no bypass, no storage
        wb(1'b1, 2'd3, 5'd8, 32'h0000_0077);
        instruction = itype(6'h08, 5'd8, 5'd0, 16'h0000);
        cyc();
        chk("rsvd_bypass", 64'(ex_rs_data), 64'h0);
        wb(1'b0, 2'd0, 5'd0, 32'h0);
        cyc();
        chk("rsvd_stored", 64'(ex_rs_data), 64'h0);

        // Immediate extension
        instruction = itype(6'h0D, 5'd0, 5'd1, 16'h8001);
        cyc();
        chk("ext_ori", 64'(ex_imm), 64'h0000_8001);
        instruction = itype(6'h0F, 5'd0, 5'd1, 16'h8001);
        cyc();
        chk("ext_lui", 64'(ex_imm), 64'h8001_0000);
        instruction = itype(6'h23, 5'd2, 5'd1, 16'h8001);
        cyc();
        chk("ext_lw", 64'(ex_imm), 64'hFFFF_8001);

        // Stall refresh with sub $2,$4,$4
        instruction = rtype(5'd4, 5'd4, 5'd2, 6'h22);
        cyc();
        chk("sub_rs_data", 64'(ex_rs_data), 64'h0);
        stall = 1'b1;
        wb(1'b1, 2'd0, 5'd4, 32'h0000_0055);
        instruction = itype(6'h0D, 5'd9, 5'd9, 16'h1111);
        cyc();
        chk("stall_rs_data", 64'(ex_rs_data), 64'h55);
        chk("stall_rt_data", 64'(ex_rt_data), 64'h55);
        chk("stall_opcode", 64'(ex_opcode), 64'h0);
        chk("stall_funct", 64'(ex_funct), 64'h22);
        chk("stall_valid", 64'(ex_valid), 64'h1);
        flush = 1'b1;
        wb(1'b0, 2'd0, 5'd0, 32'h0);
        cyc();
        chk("stall_flush_valid", 64'(ex_valid), 64'h0);
        chk("stall_flush_funct", 64'(ex_funct), 64'h0);
        stall = 1'b0; flush = 1'b0;

        // Memory writeback with bypass; fields captured with in_valid = 0
        wb(1'b1, 2'd1, 5'd10, 32'hCAFE_F00D);
        in_valid = 1'b0;
        instruction = itype(6'h08, 5'd10, 5'd4, 16'h0004);
        cyc();
        chk("mem_bypass", 64'(ex_rs_data), 64'hCAFE_F00D);
        chk("invalid_valid", 64'(ex_valid), 64'h0);
        chk("invalid_rs", 64'(ex_rs), 64'hA);

        // Reset drops a concurrent write
        in_valid = 1'b1;
        wb(1'b1, 2'd0, 5'd9, 32'h0000_0011);
        cyc();
        reset = 1'b1;
        wb(1'b1, 2'd0, 5'd9, 32'h0000_00AB);
        cyc();
        reset = 1'b0;
        wb(1'b0, 2'd0, 5'd0, 32'h0);
        instruction = itype(6'h08, 5'd9, 5'd4, 16'h0000);
        cyc();
        chk("reset_r9", 64'(ex_rs_data), 64'h0);
        chk("reset_r4", 64'(ex_rt_data), 64'h0);

        // Mixed traffic on a few registers, checked by the model
        for (int n = 0; n < 80; n++) begin
            reset       = ($urandom_range(31) == 0);
            in_valid    = 1'($urandom_range(1));
            instruction = $urandom;
            instruction[25:21] = 5'($urandom_range(7));
            instruction[20:16] = 5'($urandom_range(7));
            instruction[31:26] = 6'($urandom_range(5) + 11);
            pc_plus4    = $urandom;
            stall       = ($urandom_range(3) == 0);
            flush       = ($urandom_range(7) == 0);
            wb_we       = 1'($urandom_range(1));
            wb_src      = 2'($urandom_range(3));
            wb_dst      = 5'($urandom_range(7));
            alu_result  = $urandom;
            mem_data    = $urandom;
            link_data   = $urandom;
            cyc();
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0; wb_we = 1'b0;

        // 64-bit data, 16 registers, link register 15
        w_reset = 1'b0; w_in_valid = 1'b1; w_pc_plus4 = 64'h1_0000_0004;
        w_instruction = itype(6'h23, 5'd31, 5'd2, 16'h8001);
        cyc();
        chk("w_ext_lw", w_ex_imm, 64'hFFFF_FFFF_FFFF_8001);
        chk("w_rs_trunc", 64'(w_ex_rs), 64'hF);
        chk("w_pc", w_ex_pc_plus4, 64'h1_0000_0004);
        w_instruction = itype(6'h0F, 5'd0, 5'd2, 16'h8001);
        cyc();
        chk("w_ext_lui", w_ex_imm, 64'hFFFF_FFFF_8001_0000);
        w_wb_we = 1'b1; w_wb_src = 2'd2; w_wb_dst = 4'd3;
        w_link_data = 64'h1234_5678_9ABC_DEF0; w_alu_result = 64'h1; w_mem_data = 64'h2;
        w_instruction = itype(6'h08, 5'd15, 5'd3, 16'h0000);
        cyc();
        chk("w_link_bypass", w_ex_rs_data, 64'h1234_5678_9ABC_DEF0);
        chk("w_link_r3", w_ex_rt_data, 64'h0);
        w_wb_we = 1'b0;
        cyc();
        chk("w_link_stored", w_ex_rs_data, 64'h1234_5678_9ABC_DEF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_regfile.md
# id_stage_regfile

Parametrised decode stage for the pipelined MIPS core, replacing the single-cycle decoder/register file. It holds the general-purpose register file, selects the writeback source, and forwards same-cycle writebacks to the read ports. It extends immediates per opcode and registers everything into an ID/EX pipeline register with valid, stall and flush control, sitting between the IF/ID latch and the execute stage.

## Interface
- DATA_W, 32: register/datapath width; must be ≥ 32.
- ADDR_W, 5: register address width; register count = 2^ADDR_W; register 0 is hard-wired zero.
- LINK_REG, 31: destination forced by link writebacks.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears register file and ID/EX register
- in_valid  in  1  instruction/pc_plus4 carry a real instruction this cycle
- instruction  in  32  instruction word from IF/ID
- pc_plus4  in  DATA_W  PC+4 of that instruction
- stall  in  1  hold the ID/EX register (operands refreshed, see Operation)
- flush  in  1  load a bubble into ID/EX
- wb_we  in  1  writeback enable
- wb_src  in  2  0 = alu_result, 1 = mem_data, 2 = link_data, 3 = reserved (no write)
- wb_dst  in  ADDR_W  writeback register; ignored when wb_src = 2
- alu_result, mem_data, link_data  in  DATA_W each  writeback candidates
- ex_valid  out  1  ID/EX holds a real instruction
- ex_rs_data, ex_rt_data  out  DATA_W  operand values
- ex_imm  out  DATA_W  extended immediate
- ex_rs, ex_rt, ex_rd  out  ADDR_W  register fields (low ADDR_W bits of instruction[25:21], [20:16], [15:11])
- ex_opcode, ex_funct  out  6 each  instruction[31:26], [5:0]
- ex_pc_plus4  out  DATA_W  registered pc_plus4

## Operation
- Writeback: effective address = LINK_REG if wb_src = 2, else wb_dst. Effective data = the mux selection. A write occurs at the clock edge when wb_we = 1, wb_src ≠ 3, address ≠ 0 and reset = 0.
- Read: register[rs], register[rt]; address 0 always reads 0.
- Bypass: if a write occurs this cycle to a nonzero address equal to rs (or rt), the read returns the effective write data instead of the stored value. This makes write-then-read in the same cycle visible with no extra latency.
- Immediate extension by opcode:
  - 0x0C/0x0D/0x0E (andi/ori/xori): zero-extend instruction[15:0].
  - 0x0F (lui): {instruction[15:0], 16'b0}, sign-extended to DATA_W from bit 31.
  - All others: sign-extend from bit 15.
- ID/EX update priority per edge: reset > flush > stall > load.
  - reset: all ex_* outputs ← 0, ex_valid ← 0; all registers ← 0; any concurrent writeback is dropped.
  - flush: ex_valid ← 0, all other ex_* ← 0; register-file write still occurs.
  - stall: ex_valid, ex_imm, ex_rs/rt/rd, ex_opcode, ex_funct and ex_pc_plus4 hold. ex_rs_data/ex_rt_data reload from the bypassed read of the held ex_rs/ex_rt, so a writeback landing during a stall is not lost.
  - load: all ex_* ← decoded fields of the current instruction; ex_valid ← in_valid. Fields are captured even when in_valid = 0.

## Timing
- Decode-to-ID/EX latency: 1 cycle. A register write is visible in ex_*_data at the same edge via bypass, and in storage from the next cycle.
- Reset value of every output: 0.
- No combinational path from inputs to outputs; all outputs are flops.
- Stall and flush asserted together: flush wins.
- Writeback to register 0, or with wb_src = 3: no state change and no bypass.

## Test plan
- Reset then read: assert reset 1 cycle; load `add $3,$1,$2` → ex_rs_data = ex_rt_data = 0, ex_valid = 1 after the next edge.
- Bypass: wb_we = 1, wb_src = 0, wb_dst = 5, alu_result = 0x1234 in the same cycle as `addi $6,$5,-1` is loaded → next edge ex_rs_data = 0x1234, ex_imm = 0xFFFFFFFF.
- Link and zero: wb_src = 2, link_data = 0x0040_0008, wb_dst = 7 → register 31 = 0x0040_0008 and register 7 unchanged. A write of 0xDEAD to register 0 → register 0 still reads 0.
- Extension: ori imm 0x8001 → ex_imm = 0x0000_8001; lui imm 0x8001 → 0x8001_0000; lw offset 0x8001 → 0xFFFF_8001.
- Stall refresh: hold stall with `sub $2,$4,$4` in ID/EX, then write 0x55 to $4 → ex_rs_data = ex_rt_data = 0x55 after that edge while ex_opcode and ex_funct are unchanged. Assert stall and flush together → ex_valid = 0.
- Reset mid-write: reset = 1 with wb_we = 1 to $9 = 0xAB → $9 reads 0 afterwards. Parameter sweep at DATA_W = 64, ADDR_W = 4: sign-extension fills to bit 63, and ex_rs is 4 bits wide.
